// File: rtl/multihat_pkg.sv
// Shared types, reset seeds and ap_return field layout for the multi-hat
// Gaussian generator, plus the scaling and saturation helpers.
package multihat_pkg;

    typedef logic signed [15:0] sample_t;

    localparam logic [15:0] SEED_U1_DEF   = 16'hACE1;
    localparam logic [15:0] SEED_U2_DEF   = 16'h1234;
    localparam logic [15:0] SEED_U3_DEF   = 16'hBEEF;
    localparam logic [15:0] SEED_U4_DEF   = 16'h5A5A;
    localparam logic [15:0] SEED_SEL_DEF  = 16'hC0DE;
    localparam logic [15:0] POLY_MASK_DEF = 16'hB400;

    localparam int unsigned PIPE_DEPTH = 5;

    // Low bit of each 16-bit field inside the 288-bit ap_return bus.
    localparam int unsigned OFF_C5Z  = 272;
    localparam int unsigned OFF_C5Z1 = 256;
    localparam int unsigned OFF_C5Z2 = 240;
    localparam int unsigned OFF_C4Z  = 224;
    localparam int unsigned OFF_C4Z1 = 208;
    localparam int unsigned OFF_C4Z2 = 192;
    localparam int unsigned OFF_C3Z  = 176;
    localparam int unsigned OFF_C3Z1 = 160;
    localparam int unsigned OFF_C3Z2 = 144;
    localparam int unsigned OFF_C2Z  = 128;
    localparam int unsigned OFF_C2Z1 = 112;
    localparam int unsigned OFF_C2Z2 = 96;
    localparam int unsigned OFF_SEL  = 80;
    localparam int unsigned OFF_OUT  = 64;
    localparam int unsigned OFF_U1   = 48;
    localparam int unsigned OFF_U2   = 32;
    localparam int unsigned OFF_U3   = 16;
    localparam int unsigned OFF_U4   = 0;

    // Only the low two select bits matter: shift amount is 2..5.
    function automatic sample_t scale_uniform(input sample_t v, input logic [3:0] sel);
        return v >>> (3'(sel[1:0]) + 3'd2);
    endfunction

    function automatic sample_t sat16(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// Right-shifting 16-bit Galois LFSR that advances only when enabled.
module lfsr16_galois #(
    parameter logic [15:0] SEED = 16'h0001,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: shift right and fold in the feedback mask when a 1 falls out.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? MASK : 16'h0000);
        end else begin
            state_d = state_q;
        end
    end

    // State register, loads the seed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/multihat_grng.sv
// Multi-hat Gaussian RNG: four scaled uniforms summed through a 4-stage
// shift/add pipeline, with every stage exposed on ap_return.
module multihat_grng
    import multihat_pkg::*;
#(
    parameter logic [15:0] SEED_U1   = SEED_U1_DEF,
    parameter logic [15:0] SEED_U2   = SEED_U2_DEF,
    parameter logic [15:0] SEED_U3   = SEED_U3_DEF,
    parameter logic [15:0] SEED_U4   = SEED_U4_DEF,
    parameter logic [15:0] SEED_SEL  = SEED_SEL_DEF,
    parameter logic [15:0] POLY_MASK = POLY_MASK_DEF
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         ap_start,
    output logic         ap_done,
    output logic         ap_idle,
    output logic         ap_ready,
    output logic [287:0] ap_return
);

    localparam logic [2:0] DONE_CNT = 3'(PIPE_DEPTH);

    logic [15:0] u1_s, u2_s, u3_s, u4_s, sel_s;

    lfsr16_galois #(.SEED(SEED_U1),  .MASK(POLY_MASK)) u_lfsr_u1  (.clk(ap_clk), .rst_n(ap_rst), .en(ap_start), .state(u1_s));
    lfsr16_galois #(.SEED(SEED_U2),  .MASK(POLY_MASK)) u_lfsr_u2  (.clk(ap_clk), .rst_n(ap_rst), .en(ap_start), .state(u2_s));
    lfsr16_galois #(.SEED(SEED_U3),  .MASK(POLY_MASK)) u_lfsr_u3  (.clk(ap_clk), .rst_n(ap_rst), .en(ap_start), .state(u3_s));
    lfsr16_galois #(.SEED(SEED_U4),  .MASK(POLY_MASK)) u_lfsr_u4  (.clk(ap_clk), .rst_n(ap_rst), .en(ap_start), .state(u4_s));
    lfsr16_galois #(.SEED(SEED_SEL), .MASK(POLY_MASK)) u_lfsr_sel (.clk(ap_clk), .rst_n(ap_rst), .en(ap_start), .state(sel_s));

    sample_t c2z1_q, c2z2_q, c3z1_q, c3z2_q, c4z1_q, c4z2_q, c5z1_q, c5z2_q, out_q;
    sample_t c2z1_d, c2z2_d, c3z1_d, c3z2_d, c4z1_d, c4z2_d, c5z1_d, c5z2_d, out_d;
    logic [2:0] cnt_q, cnt_d;

    sample_t     c2z_s, c3z_s, c4z_s, c5z_s;
    logic [16:0] c5z_wide_s;

    // Stage sums; only the final stage can exceed 16 bits and is saturated.
    always_comb begin
        c2z_s      = c2z1_q + c2z2_q;
        c3z_s      = c3z1_q + c3z2_q;
        c4z_s      = c4z1_q + c4z2_q;
        c5z_wide_s = {c5z1_q[15], c5z1_q} + {c5z2_q[15], c5z2_q};
        c5z_s      = sat16(c5z_wide_s);
    end

    // Pipeline next state: advance on ap_start, otherwise hold everything.
    always_comb begin
        c2z1_d = c2z1_q;
        c2z2_d = c2z2_q;
        c3z1_d = c3z1_q;
        c3z2_d = c3z2_q;
        c4z1_d = c4z1_q;
        c4z2_d = c4z2_q;
        c5z1_d = c5z1_q;
        c5z2_d = c5z2_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        if (ap_start) begin
            c2z1_d = scale_uniform(sample_t'(u1_s), sel_s[3:0]);
            c2z2_d = scale_uniform(sample_t'(u2_s), sel_s[7:4]);
            c3z1_d = c2z_s;
            c3z2_d = scale_uniform(sample_t'(u3_s), sel_s[11:8]);
            c4z1_d = c3z_s;
            c4z2_d = scale_uniform(sample_t'(u4_s), sel_s[15:12]);
            c5z1_d = c4z_s;
            c5z2_d = c2z_s >>> 1;
            out_d  = c5z_s;
            cnt_d  = (cnt_q == DONE_CNT) ? cnt_q : cnt_q + 3'd1;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Pipeline and valid-counter registers.
    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            c2z1_q <= 16'h0000;
            c2z2_q <= 16'h0000;
            c3z1_q <= 16'h0000;
            c3z2_q <= 16'h0000;
            c4z1_q <= 16'h0000;
            c4z2_q <= 16'h0000;
            c5z1_q <= 16'h0000;
            c5z2_q <= 16'h0000;
            out_q  <= 16'h0000;
            cnt_q  <= 3'd0;
        end else begin
            c2z1_q <= c2z1_d;
            c2z2_q <= c2z2_d;
            c3z1_q <= c3z1_d;
            c3z2_q <= c3z2_d;
            c4z1_q <= c4z1_d;
            c4z2_q <= c4z2_d;
            c5z1_q <= c5z1_d;
            c5z2_q <= c5z2_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ap_done  = ap_start && (cnt_q == DONE_CNT);
    assign ap_idle  = !ap_start;
    assign ap_ready = ap_start;

    assign ap_return[OFF_C5Z  +: 16] = c5z_s;
    assign ap_return[OFF_C5Z1 +: 16] = c5z1_q;
    assign ap_return[OFF_C5Z2 +: 16] = c5z2_q;
    assign ap_return[OFF_C4Z  +: 16] = c4z_s;
    assign ap_return[OFF_C4Z1 +: 16] = c4z1_q;
    assign ap_return[OFF_C4Z2 +: 16] = c4z2_q;
    assign ap_return[OFF_C3Z  +: 16] = c3z_s;
    assign ap_return[OFF_C3Z1 +: 16] = c3z1_q;
    assign ap_return[OFF_C3Z2 +: 16] = c3z2_q;
    assign ap_return[OFF_C2Z  +: 16] = c2z_s;
    assign ap_return[OFF_C2Z1 +: 16] = c2z1_q;
    assign ap_return[OFF_C2Z2 +: 16] = c2z2_q;
    assign ap_return[OFF_SEL  +: 16] = sel_s;
    assign ap_return[OFF_OUT  +: 16] = out_q;
    assign ap_return[OFF_U1   +: 16] = u1_s;
    assign ap_return[OFF_U2   +: 16] = u2_s;
    assign ap_return[OFF_U3   +: 16] = u3_s;
    assign ap_return[OFF_U4   +: 16] = u4_s;

endmodule

// File: tb/tb_multihat_grng.sv
// Directed bench for multihat_grng: hand-computed vectors, a stall/reset
// scenario, a reference-model stream and two seeded saturation instances.
module tb_multihat_grng;

    localparam int F_C5Z = 272, F_C5Z1 = 256, F_C5Z2 = 240, F_C4Z = 224;
    localparam int F_C3Z = 176, F_C3Z1 = 160, F_C2Z = 128, F_C2Z1 = 112;
    localparam int F_C2Z2 = 96, F_SEL = 80, F_OUT = 64;
    localparam int F_U1 = 48, F_U2 = 32, F_U3 = 16, F_U4 = 0;

    logic         clk = 1'b0;
    logic         ap_rst = 1'b0;
    logic         ap_start = 1'b0;
    logic         ap_done, ap_idle, ap_ready;
    logic [287:0] ap_return;
    logic         p_done, p_idle, p_ready, n_done, n_idle, n_ready;
    logic [287:0] p_ret, n_ret;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    multihat_grng dut (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return)
    );

    // Seeds chosen so c5z1 = 7FFC and c5z2 = 04FF after the 4th enabled edge.
    multihat_grng #(.SEED_U1(16'h7FFC), .SEED_U2(16'h7FFC), .SEED_U3(16'hFFF8),
                    .SEED_U4(16'h97F1), .SEED_SEL(16'h0008)) dut_pos (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(p_done), .ap_idle(p_idle), .ap_ready(p_ready), .ap_return(p_ret)
    );

    // Seeds chosen so c5z1 = 8000 and c5z2 = F830 after the 4th enabled edge.
    multihat_grng #(.SEED_U1(16'h8003), .SEED_U2(16'h8003), .SEED_U3(16'h6801),
                    .SEED_U4(16'hD002), .SEED_SEL(16'h0008)) dut_neg (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(n_done), .ap_idle(n_idle), .ap_ready(n_ready), .ap_return(n_ret)
    );

    function automatic logic [15:0] fld(input logic [287:0] r, input int lo);
        return r[lo +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ap_start = 1'b0;
        ap_rst   = 1'b0;
        tick();
        tick();
        ap_rst   = 1'b1;
    endtask

    // Reference model state.
    logic [15:0]        m_u [4];
    logic [15:0]        m_sel;
    logic signed [15:0] m_c2z1, m_c2z2, m_c3z1, m_c3z2, m_c4z1, m_c4z2, m_c5z1, m_c5z2, m_out;

    function automatic logic [15:0] m_lfsr(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic signed [15:0] m_scale(input logic [15:0] u, input logic [3:0] s);
        int v;
        v = int'($signed(u));
        v = v >>> (int'(s[1:0]) + 2);
        return 16'(v);
    endfunction

    task automatic m_init();
        m_u[0] = 16'hACE1; m_u[1] = 16'h1234; m_u[2] = 16'hBEEF; m_u[3] = 16'h5A5A;
        m_sel  = 16'hC0DE;
        m_c2z1 = 16'sh0; m_c2z2 = 16'sh0; m_c3z1 = 16'sh0; m_c3z2 = 16'sh0;
        m_c4z1 = 16'sh0; m_c4z2 = 16'sh0; m_c5z1 = 16'sh0; m_c5z2 = 16'sh0;
        m_out  = 16'sh0;
    endtask

    task automatic m_step();
        int c2, c3, c4, c5;
        c2 = int'(m_c2z1) + int'(m_c2z2);
        c3 = int'(m_c3z1) + int'(m_c3z2);
        c4 = int'(m_c4z1) + int'(m_c4z2);
        c5 = int'(m_c5z1) + int'(m_c5z2);
        if (c5 > 32767) c5 = 32767;
        if (c5 < -32768) c5 = -32768;
        m_out  = 16'(c5);
        m_c5z1 = 16'(c4);
        m_c5z2 = 16'(c2 >>> 1);
        m_c4z1 = 16'(c3);
        m_c4z2 = m_scale(m_u[3], m_sel[15:12]);
        m_c3z1 = 16'(c2);
        m_c3z2 = m_scale(m_u[2], m_sel[11:8]);
        m_c2z1 = m_scale(m_u[0], m_sel[3:0]);
        m_c2z2 = m_scale(m_u[1], m_sel[7:4]);
        for (int i = 0; i < 4; i++) m_u[i] = m_lfsr(m_u[i]);
        m_sel = m_lfsr(m_sel);
    endtask

    task automatic test_reset();
        int offs [13];
        offs = '{256, 240, 208, 192, 160, 144, 112, 96, 272, 224, 176, 128, 64};
        do_reset();
        total_cnt++; if (fld(ap_return, F_U1) !== 16'hACE1) $display("FAIL reset_u1 got %h exp ACE1", fld(ap_return, F_U1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U2) !== 16'h1234) $display("FAIL reset_u2 got %h exp 1234", fld(ap_return, F_U2)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U3) !== 16'hBEEF) $display("FAIL reset_u3 got %h exp BEEF", fld(ap_return, F_U3)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U4) !== 16'h5A5A) $display("FAIL reset_u4 got %h exp 5A5A", fld(ap_return, F_U4)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_SEL) !== 16'hC0DE) $display("FAIL reset_sel got %h exp C0DE", fld(ap_return, F_SEL)); else pass_cnt++;
        for (int i = 0; i < 13; i++) begin
            total_cnt++;
            if (fld(ap_return, offs[i]) !== 16'h0000) $display("FAIL reset_field@%0d got %h exp 0000", offs[i], fld(ap_return, offs[i]));
            else pass_cnt++;
        end
        total_cnt++; if ({ap_done, ap_idle, ap_ready} !== 3'b010) $display("FAIL reset_ctrl got %b exp 010", {ap_done, ap_idle, ap_ready}); else pass_cnt++;
    endtask

    task automatic test_first_edge();
        ap_start = 1'b1;
        tick();
        total_cnt++; if (fld(ap_return, F_U1) !== 16'hE270) $display("FAIL e1_u1 got %h exp E270", fld(ap_return, F_U1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U2) !== 16'h091A) $display("FAIL e1_u2 got %h exp 091A", fld(ap_return, F_U2)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U3) !== 16'hEB77) $display("FAIL e1_u3 got %h exp EB77", fld(ap_return, F_U3)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U4) !== 16'h2D2D) $display("FAIL e1_u4 got %h exp 2D2D", fld(ap_return, F_U4)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_SEL) !== 16'h606F) $display("FAIL e1_sel got %h exp 606F", fld(ap_return, F_SEL)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C2Z1) !== 16'hFACE) $display("FAIL e1_c2z1 got %h exp FACE", fld(ap_return, F_C2Z1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C2Z2) !== 16'h0246) $display("FAIL e1_c2z2 got %h exp 0246", fld(ap_return, F_C2Z2)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C2Z) !== 16'hFD14) $display("FAIL e1_c2z got %h exp FD14", fld(ap_return, F_C2Z)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C3Z) !== 16'hEFBB) $display("FAIL e1_c3z got %h exp EFBB", fld(ap_return, F_C3Z)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C4Z) !== 16'h1696) $display("FAIL e1_c4z got %h exp 1696", fld(ap_return, F_C4Z)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C5Z) !== 16'h0000) $display("FAIL e1_c5z got %h exp 0000", fld(ap_return, F_C5Z)); else pass_cnt++;
        total_cnt++; if (ap_done !== 1'b0) $display("FAIL e1_done got %b exp 0", ap_done); else pass_cnt++;
    endtask

    task automatic test_second_edge();
        tick();
        total_cnt++; if (fld(ap_return, F_U1) !== 16'h7138) $display("FAIL e2_u1 got %h exp 7138", fld(ap_return, F_U1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C3Z1) !== 16'hFD14) $display("FAIL e2_c3z1 got %h exp FD14", fld(ap_return, F_C3Z1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_C5Z2) !== 16'hFE8A) $display("FAIL e2_c5z2 got %h exp FE8A", fld(ap_return, F_C5Z2)); else pass_cnt++;
        total_cnt++; if (ap_done !== 1'b0) $display("FAIL e2_done got %b exp 0", ap_done); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [287:0] snap;
        snap = ap_return;
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (ap_return !== snap) $display("FAIL stall_hold[%0d] got %h exp %h", i, ap_return, snap); else pass_cnt++;
            total_cnt++; if ({ap_done, ap_idle, ap_ready} !== 3'b010) $display("FAIL stall_ctrl[%0d] got %b exp 010", i, {ap_done, ap_idle, ap_ready}); else pass_cnt++;
        end
        total_cnt++; if (fld(ap_return, F_U1) !== 16'h7138) $display("FAIL stall_u1 got %h exp 7138", fld(ap_return, F_U1)); else pass_cnt++;
        ap_start = 1'b1;
        for (int e = 3; e <= 6; e++) begin
            tick();
            total_cnt++;
            if (ap_done !== (e >= 5)) $display("FAIL stall_done_e%0d got %b exp %b", e, ap_done, (e >= 5));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        ap_rst = 1'b0;
        #1;
        total_cnt++; if (ap_done !== 1'b0) $display("FAIL areset_done got %b exp 0", ap_done); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_U1) !== 16'hACE1) $display("FAIL areset_u1 got %h exp ACE1", fld(ap_return, F_U1)); else pass_cnt++;
        total_cnt++; if (fld(ap_return, F_OUT) !== 16'h0000) $display("FAIL areset_out got %h exp 0000", fld(ap_return, F_OUT)); else pass_cnt++;
        ap_start = 1'b0;
        tick();
        ap_rst = 1'b1;
    endtask

    task automatic test_stream();
        int sum;
        int nsamp;
        sum = 0;
        nsamp = 0;
        do_reset();
        m_init();
        ap_start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            m_step();
            tick();
            total_cnt++; if (fld(ap_return, F_OUT) !== m_out) $display("FAIL stream_out[%0d] got %h exp %h", k, fld(ap_return, F_OUT), m_out); else pass_cnt++;
            total_cnt++; if (fld(ap_return, F_U1) !== m_u[0]) $display("FAIL stream_u1[%0d] got %h exp %h", k, fld(ap_return, F_U1), m_u[0]); else pass_cnt++;
            total_cnt++; if (fld(ap_return, F_U1) === 16'h0000) $display("FAIL stream_u1_zero[%0d] got 0000 exp nonzero", k); else pass_cnt++;
            total_cnt++; if (ap_done !== (k >= 5)) $display("FAIL stream_done[%0d] got %b exp %b", k, ap_done, (k >= 5)); else pass_cnt++;
            if (k >= 5) begin
                sum = sum + int'($signed(fld(ap_return, F_OUT)));
                nsamp++;
            end
        end
        total_cnt++;
        if ((sum / nsamp) > 8192 || (sum / nsamp) < -8192) $display("FAIL stream_mean got %0d exp within +/-8192", sum / nsamp);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        ap_start = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        total_cnt++; if (fld(p_ret, F_C5Z1) !== 16'h7FFC) $display("FAIL satp_c5z1 got %h exp 7FFC", fld(p_ret, F_C5Z1)); else pass_cnt++;
        total_cnt++; if (fld(p_ret, F_C5Z2) !== 16'h04FF) $display("FAIL satp_c5z2 got %h exp 04FF", fld(p_ret, F_C5Z2)); else pass_cnt++;
        total_cnt++; if (fld(p_ret, F_C5Z) !== 16'h7FFF) $display("FAIL satp_c5z got %h exp 7FFF", fld(p_ret, F_C5Z)); else pass_cnt++;
        total_cnt++; if (fld(n_ret, F_C5Z1) !== 16'h8000) $display("FAIL satn_c5z1 got %h exp 8000", fld(n_ret, F_C5Z1)); else pass_cnt++;
        total_cnt++; if (fld(n_ret, F_C5Z2) !== 16'hF830) $display("FAIL satn_c5z2 got %h exp F830", fld(n_ret, F_C5Z2)); else pass_cnt++;
        total_cnt++; if (fld(n_ret, F_C5Z) !== 16'h8000) $display("FAIL satn_c5z got %h exp 8000", fld(n_ret, F_C5Z)); else pass_cnt++;
        tick();
        total_cnt++; if (fld(p_ret, F_OUT) !== 16'h7FFF) $display("FAIL satp_out got %h exp 7FFF", fld(p_ret, F_OUT)); else pass_cnt++;
        total_cnt++; if (fld(n_ret, F_OUT) !== 16'h8000) $display("FAIL satn_out got %h exp 8000", fld(n_ret, F_OUT)); else pass_cnt++;
        total_cnt++;
        if ({p_done, p_idle, p_ready, n_done, n_idle, n_ready} !== 6'b101101)
            $display("FAIL sat_ctrl got %b exp 101101", {p_done, p_idle, p_ready, n_done, n_idle, n_ready});
        else pass_cnt++;
        ap_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_second_edge();
        test_stall();
        test_async_reset();
        test_stream();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
